mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the pipelined datapath's instruction and data ports. It accepts iREN and dREN/dWEN requests and arbitrates them, with data having priority. It runs one access at a time against a variable-latency RAM and returns a one-cycle ihit or dhit pulse with load data. These hit pulses are what the datapath uses to enable its pipeline latches, including the MEM/WB latch. A wait-cycle watchdog prevents a hung RAM from stalling the pipeline forever.

## Interface
- TIMEOUT, default 255: maximum number of RAM wait cycles before an access is aborted (range 1..255).
- ERRWORD, default 32'hBAD1BAD1: load value returned on an aborted access.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- ihit  out  1  one-cycle instruction completion pulse.
- iload  out  32  instruction word; valid while ihit=1.
- dhit  out  1  one-cycle data completion pulse.
- dload  out  32  data load value; valid while dhit=1 for reads; 0 for writes.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramrdy=1.
- ramrdy  in  1  RAM completion; one-cycle pulse.
- err  out  1  sticky flag, set by any timeout, cleared only by reset.

## Operation
- FSM states: IDLE, DACC, IACC, RESP.
- IDLE
  - If dREN|dWEN, latch daddr/dstore/op and go to DACC.
  - Else if iREN, latch iaddr and go to IACC.
  - Else stay in IDLE.
  - Data wins whenever both sides request.
- dREN and dWEN both high: treat as a write; dREN is ignored.
- DACC/IACC
  - ram outputs are registered and driven from the latched request.
  - ramREN=1 for reads and instruction fetches; ramWEN=1 for writes.
  - An 8-bit wait counter starts at 0 on entry and increments each cycle ramrdy=0.
- Completion: ramrdy=1 in DACC/IACC captures ramload (reads), drops ram strobes at that edge, and moves to RESP.
- Timeout: if the wait counter equals TIMEOUT with ramrdy=0, the block captures ERRWORD, sets err, drops ram strobes and moves to RESP.
- RESP
  - Assert exactly one of ihit or dhit, matching the access that just finished, with iload/dload driven from the capture register.
  - Unconditional next state: IDLE.
- The block does not sample requests in RESP. The datapath drops or changes its request on the edge that ends RESP, so no request is issued twice.
- A request deasserted early (before the hit) does not abort an in-flight access; the hit is still issued.
- ramrdy while IDLE or RESP is ignored.
- ramaddr/ramstore hold their last value when strobes are low.

## Timing
- Reset values (asynchronous): state=IDLE, ihit=dhit=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, wait counter=0, err=0.
- Reset mid-access drops ram strobes immediately; no hit is issued for the aborted access.
- Request sampled at edge E0 (end of IDLE cycle) → ram strobe visible in cycle after E0.
- ramrdy sampled high at edge E1 → hit visible in the cycle after E1, for exactly one cycle.
- Minimum request-to-hit latency: 2 cycles (ramrdy in first access cycle).
- Back-to-back accesses: at least one IDLE cycle separates RESP from the next access. Steady-state throughput is one access per (RAM latency + 2) cycles.
- Timeout with TIMEOUT=N: the strobe stays high for N+1 cycles, and the hit appears in the following cycle.
- ihit and dhit are never high in the same cycle.

## Test plan
- Reset: hold nRST=0 with iREN=1 and ramrdy toggling → all outputs 0, state IDLE. Release, then ramrdy=1 on the first access cycle → ihit pulses in the 2nd cycle after release, with iload=ramload.
- Data read with priority: iREN=1, dREN=1, daddr=0x40, RAM latency 3 → ramREN with ramaddr=0x40 first. dhit with dload=ramload follows, then IDLE, then the instruction access; ihit follows later.
- Write: dWEN=1, dREN=1, daddr=0x80, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dhit with dload=0.
- Timeout: TIMEOUT=4, ramrdy never asserted → strobe high 5 cycles, then dhit with dload=0xBAD1BAD1 and err=1. err stays 1 across later good accesses until nRST.
- Stray/early: ramrdy pulse in IDLE → no hit. dREN dropped mid-access → dhit still issued once; no second access starts.
- Reset mid-access: nRST low during a DACC wait → strobes drop asynchronously, and no dhit appears after release.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates instruction/data requests (data first), runs one
// variable-latency RAM access at a time, and returns a one-cycle hit with a wait-cycle watchdog.
module mem_responder #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramrdy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state, next_state;
    logic [7:0]  wcnt;
    logic [31:0] cap;
    logic        is_data;
    logic        is_wr;
    logic        take_d, take_i, done_ok, done_to;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        take_d     = 1'b0;
        take_i     = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (dREN || dWEN) begin
                    take_d     = 1'b1;
                    next_state = DACC;
                end else if (iREN) begin
                    take_i     = 1'b1;
                    next_state = IACC;
                end
            end
            DACC, IACC: begin
                if (ramrdy) begin
                    done_ok    = 1'b1;
                    next_state = RESP;
                end else if (wcnt == TMO) begin
                    done_to    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Access datapath: strobes/address registered from the latched request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            wcnt     <= '0;
            cap      <= '0;
            is_data  <= 1'b0;
            is_wr    <= 1'b0;
            err      <= 1'b0;
        end else if (take_d) begin
            is_data  <= 1'b1;
            is_wr    <= dWEN;
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
            wcnt     <= '0;
        end else if (take_i) begin
            is_data  <= 1'b0;
            is_wr    <= 1'b0;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= iaddr;
            wcnt     <= '0;
        end else if (done_ok) begin
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            cap      <= is_wr ? '0 : ramload;
        end else if (done_to) begin
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            cap      <= ERRWORD;
            err      <= 1'b1;
        end else if (state == DACC || state == IACC) begin
            wcnt     <= wcnt + 8'd1;
        end
    end

    assign ihit  = (state == RESP) && !is_data;
    assign dhit  = (state == RESP) && is_data;
    assign iload = ihit ? cap : '0;
    assign dload = dhit ? cap : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected hits; a negedge
// monitor pops and compares every hit the DUT presents.
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [31:0] ramload = '0;
    logic        ramrdy = 1'b0;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    mem_responder #(.TIMEOUT(4), .ERRWORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramrdy(ramrdy), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every hit must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (nRST && (ihit || dhit)) begin
            exp_t e;
            compared++;
            if (ihit && dhit) begin
                mismatched++;
                $display("FAIL both_hits: ihit=%b dhit=%b expected one", ihit, dhit);
            end else if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_hit: ihit=%b dhit=%b iload=%h dload=%h expected none",
                         ihit, dhit, iload, dload);
            end else begin
                e = exp_q.pop_front();
                if (dhit !== e.is_d || (e.is_d ? dload : iload) !== e.data) begin
                    mismatched++;
                    $display("FAIL hit_data: dhit=%b load=%h expected dhit=%b load=%h",
                             dhit, e.is_d ? dload : iload, e.is_d, e.data);
                end
            end
        end
    end

    // RAM model: wait for a strobe, check it, then answer after lat cycles.
    task automatic serve(input logic er, input logic ew, input logic [31:0] ea,
                         input logic [31:0] es, input logic cs, input int lat,
                         input logic [31:0] ld, input logic drop);
        int n = 0;
        while (!(ramREN || ramWEN) && n < 20) begin
            step();
            n++;
        end
        chk("strobe_seen", {31'b0, ramREN || ramWEN}, 32'd1);
        chk("ramREN", {31'b0, ramREN}, {31'b0, er});
        chk("ramWEN", {31'b0, ramWEN}, {31'b0, ew});
        chk("ramaddr", ramaddr, ea);
        if (cs) chk("ramstore", ramstore, es);
        if (drop) begin
            iREN = 1'b0;
            dREN = 1'b0;
            dWEN = 1'b0;
        end
        repeat (lat - 1) step();
        ramrdy  = 1'b1;
        ramload = ld;
        step();
        ramrdy  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset with requests and stray ramrdy
        iREN  = 1'b1;
        iaddr = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            ramrdy = ~ramrdy;
            step();
            chk("rst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
            chk("rst_ramaddr", ramaddr, 32'd0);
            chk("rst_ramstore", ramstore, 32'd0);
            chk("rst_hits", {30'b0, ihit, dhit}, 32'd0);
            chk("rst_loads", iload | dload, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
        end
        ramrdy = 1'b0;
        nRST   = 1'b1;
        push(1'b0, 32'h1111_2222);
        step();
        chk("first_fetch_ren", {31'b0, ramREN}, 32'd1);
        chk("first_fetch_addr", ramaddr, 32'h0000_0100);
        ramrdy  = 1'b1;
        ramload = 32'h1111_2222;
        step();
        ramrdy = 1'b0;
        chk("ihit_2nd_cycle", {31'b0, ihit}, 32'd1);
        iREN = 1'b0;
        step();

        // Data wins over a simultaneous fetch
        iREN  = 1'b1;
        iaddr = 32'h0000_0200;
        dREN  = 1'b1;
        daddr = 32'h0000_0040;
        push(1'b1, 32'hCAFE_0001);
        push(1'b0, 32'h1234_5678);
        serve(1'b1, 1'b0, 32'h40, '0, 1'b0, 3, 32'hCAFE_0001, 1'b0);
        chk("dhit_prio", {31'b0, dhit}, 32'd1);
        dREN = 1'b0;
        step();
        chk("idle_gap", {30'b0, ramREN, ramWEN}, 32'd0);
        serve(1'b1, 1'b0, 32'h200, '0, 1'b0, 2, 32'h1234_5678, 1'b0);
        iREN = 1'b0;
        step();

        // Write with dREN also high
        dWEN   = 1'b1;
        dREN   = 1'b1;
        daddr  = 32'h0000_0080;
        dstore = 32'hDEAD_BEEF;
        push(1'b1, 32'h0);
        serve(1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 1'b1, 2, 32'h5555_5555, 1'b0);
        dWEN = 1'b0;
        dREN = 1'b0;
        step();

        // Timeout: strobe high TIMEOUT+1 cycles, then error word
        dREN  = 1'b1;
        daddr = 32'h0000_0300;
        push(1'b1, 32'hBAD1_BAD1);
        n = 0;
        while (!ramREN && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (ramREN && n < 20) begin
            step();
            n++;
        end
        chk("timeout_strobe_cycles", n, 32'd5);
        chk("timeout_dhit", {31'b0, dhit}, 32'd1);
        chk("timeout_err", {31'b0, err}, 32'd1);
        dREN = 1'b0;
        step();
        iREN  = 1'b1;
        iaddr = 32'h0000_0400;
        push(1'b0, 32'h0BAD_F00D);
        serve(1'b1, 1'b0, 32'h400, '0, 1'b0, 1, 32'h0BAD_F00D, 1'b0);
        iREN = 1'b0;
        step();
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Stray ramrdy in IDLE
        ramrdy = 1'b1;
        step();
        ramrdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_no_hit", {30'b0, ihit, dhit}, 32'd0);
            step();
        end

        // Request dropped mid-access still completes once
        dREN  = 1'b1;
        daddr = 32'h0000_0500;
        push(1'b1, 32'h0A0A_0A0A);
        serve(1'b1, 1'b0, 32'h500, '0, 1'b0, 3, 32'h0A0A_0A0A, 1'b1);
        chk("early_drop_dhit", {31'b0, dhit}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_second_access", {30'b0, ramREN, ramWEN}, 32'd0);
        end

        // Reset during a data wait
        dREN  = 1'b1;
        daddr = 32'h0000_0600;
        step();
        step();
        chk("pre_reset_strobe", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("async_strobe_drop", {30'b0, ramREN, ramWEN}, 32'd0);
        chk("reset_clears_err", {31'b0, err}, 32'd0);
        dREN = 1'b0;
        step();
        step();
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_reset_idle", {29'b0, ramREN, ihit, dhit}, 32'd0);
        end

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
